// File: rtl/wave_config_sequencer_if.sv
// Host configuration bus for the wave generator bank: write port, commit/clear
// controls and the active parameter buses driven back to the generators.
interface wave_config_sequencer_if #(
  parameter int NCHAN = 32,
  parameter int DW    = 16
);
  logic                  wr_valid;
  logic                  wr_ready;
  logic [4:0]            wr_chan;
  logic [1:0]            wr_field;
  logic [DW-1:0]         wr_data;
  logic                  commit_req;
  logic                  commit_realign;
  logic                  sync_tick;
  logic                  clear_req;
  logic [NCHAN*DW-1:0]   amps;
  logic [NCHAN*DW-1:0]   offsets;
  logic [NCHAN*DW-1:0]   phasewords;
  logic                  gen_reset;
  logic                  commit_done;
  logic                  clear_done;
  logic                  busy;
  logic                  cfg_err;

  modport slave (
    input  wr_valid, wr_chan, wr_field, wr_data,
    input  commit_req, commit_realign, sync_tick, clear_req,
    output wr_ready, amps, offsets, phasewords,
    output gen_reset, commit_done, clear_done, busy, cfg_err
  );

  modport master (
    output wr_valid, wr_chan, wr_field, wr_data,
    output commit_req, commit_realign, sync_tick, clear_req,
    input  wr_ready, amps, offsets, phasewords,
    input  gen_reset, commit_done, clear_done, busy, cfg_err
  );
endinterface

// File: rtl/wave_config_sequencer.sv
// Shadow/active configuration register file for the wave generator bank with
// frame-aligned atomic commit, optional generator realign pulse and amp clear.

// One channel: shadow amp/offset/phaseword plus the active copy loaded on apply.
module wcs_chan #(
  parameter int DW = 16
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          wr_en_i,
  input  logic [1:0]    wr_field_i,
  input  logic [DW-1:0] wr_data_i,
  input  logic          clr_en_i,
  input  logic          apply_en_i,
  output logic [DW-1:0] amp_o,
  output logic [DW-1:0] off_o,
  output logic [DW-1:0] ph_o
);
  logic [DW-1:0] sh_amp_q, sh_off_q, sh_ph_q;
  logic [DW-1:0] act_amp_q, act_off_q, act_ph_q;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      sh_amp_q  <= '0;
      sh_off_q  <= '0;
      sh_ph_q   <= '0;
      act_amp_q <= '0;
      act_off_q <= '0;
      act_ph_q  <= '0;
    end else begin
      if (wr_en_i) begin
        case (wr_field_i)
          2'd0:    sh_amp_q <= wr_data_i;
          2'd1:    sh_off_q <= wr_data_i;
          2'd2:    sh_ph_q  <= wr_data_i;
          default: ;
        endcase
      end
      if (clr_en_i) sh_amp_q <= '0;
      if (apply_en_i) begin
        act_amp_q <= sh_amp_q;
        act_off_q <= sh_off_q;
        act_ph_q  <= sh_ph_q;
      end
    end
  end

  assign amp_o = act_amp_q;
  assign off_o = act_off_q;
  assign ph_o  = act_ph_q;
endmodule

module wave_config_sequencer #(
  parameter int NCHAN = 32,
  parameter int DW    = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  wave_config_sequencer_if.slave  bus
);
  localparam int CW = (NCHAN > 1) ? $clog2(NCHAN) : 1;

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_PEND  = 2'd1;
  localparam logic [1:0] S_APPLY = 2'd2;
  localparam logic [1:0] S_CLEAR = 2'd3;

  logic [1:0]    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic          realign_q, realign_d;
  logic          cfg_err_q, cfg_err_d;
  logic          commit_done_q, commit_done_d;
  logic          clear_done_q, clear_done_d;
  logic          gen_reset_q, gen_reset_d;

  logic          wr_ready;
  logic          wr_acc;
  logic          wr_legal;
  logic [31:0]   chan_w;
  logic          apply_en;

  logic [NCHAN-1:0][DW-1:0] amp_w, off_w, ph_w;

  assign wr_ready = (state_q == S_IDLE) && !reset;
  assign wr_acc   = bus.wr_valid && wr_ready;
  assign chan_w   = 32'(bus.wr_chan);
  // Out-of-range channel or field 3 still completes the handshake but only flags.
  assign wr_legal = (bus.wr_field != 2'd3) && (chan_w < 32'(NCHAN));
  assign apply_en = (state_q == S_PEND) && bus.sync_tick;

  always_comb begin
    state_d       = state_q;
    cnt_d         = cnt_q;
    realign_d     = realign_q;
    cfg_err_d     = cfg_err_q;
    commit_done_d = 1'b0;
    clear_done_d  = 1'b0;
    gen_reset_d   = 1'b0;
    if (wr_acc && !wr_legal) cfg_err_d = 1'b1;
    case (state_q)
      S_IDLE: begin
        if (bus.clear_req) begin
          state_d = S_CLEAR;
          cnt_d   = '0;
        end else if (bus.commit_req) begin
          state_d   = S_PEND;
          realign_d = bus.commit_realign;
        end
      end
      S_PEND: begin
        if (bus.sync_tick) begin
          state_d       = S_APPLY;
          commit_done_d = 1'b1;
          gen_reset_d   = realign_q;
        end
      end
      S_APPLY: state_d = S_IDLE;
      S_CLEAR: begin
        // Last channel zeroed this cycle; done pulse lands in the first IDLE cycle.
        if (cnt_q == CW'(NCHAN - 1)) begin
          state_d      = S_IDLE;
          clear_done_d = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q       <= S_IDLE;
      cnt_q         <= '0;
      realign_q     <= 1'b0;
      cfg_err_q     <= 1'b0;
      commit_done_q <= 1'b0;
      clear_done_q  <= 1'b0;
      gen_reset_q   <= 1'b0;
    end else begin
      state_q       <= state_d;
      cnt_q         <= cnt_d;
      realign_q     <= realign_d;
      cfg_err_q     <= cfg_err_d;
      commit_done_q <= commit_done_d;
      clear_done_q  <= clear_done_d;
      gen_reset_q   <= gen_reset_d;
    end
  end

  for (genvar n = 0; n < NCHAN; n++) begin : g_chan
    logic wr_en, clr_en;
    assign wr_en  = wr_acc && wr_legal && (chan_w == 32'(n));
    assign clr_en = (state_q == S_CLEAR) && (cnt_q == CW'(n));
    wcs_chan #(.DW(DW)) u_chan (
      .clk        (clk),
      .reset      (reset),
      .wr_en_i    (wr_en),
      .wr_field_i (bus.wr_field),
      .wr_data_i  (bus.wr_data),
      .clr_en_i   (clr_en),
      .apply_en_i (apply_en),
      .amp_o      (amp_w[n]),
      .off_o      (off_w[n]),
      .ph_o       (ph_w[n])
    );
  end

  assign bus.wr_ready    = wr_ready;
  assign bus.amps        = amp_w;
  assign bus.offsets     = off_w;
  assign bus.phasewords  = ph_w;
  assign bus.gen_reset   = gen_reset_q;
  assign bus.commit_done = commit_done_q;
  assign bus.clear_done  = clear_done_q;
  assign bus.busy        = (state_q != S_IDLE);
  assign bus.cfg_err     = cfg_err_q;
endmodule

// File: tb/tb_wave_config_sequencer.sv
// Bench for wave_config_sequencer: directed scenarios plus random traffic,
// all outputs compared every cycle against a transaction-level model.
module tb_wave_config_sequencer;
  localparam int NCHAN = 32;
  localparam int DW    = 16;
  localparam int W     = NCHAN * DW;

  logic clk   = 1'b0;
  logic reset = 1'b1;
  always #5 clk = ~clk;

  wave_config_sequencer_if #(.NCHAN(NCHAN), .DW(DW)) bus ();
  wave_config_sequencer #(.NCHAN(NCHAN), .DW(DW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int checks = 0;
  int errors = 0;

  task automatic chk(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Model: shadow/active arrays indexed [field][chan], plus a coarse phase.
  typedef enum int {M_IDLE, M_PEND, M_APPLY, M_CLEAR} mph_t;
  logic [DW-1:0] sh  [3][NCHAN];
  logic [DW-1:0] act [3][NCHAN];
  mph_t m_ph     = M_IDLE;
  int   m_cnt    = 0;
  bit   m_realign = 0;
  bit   m_err = 0, m_cd = 0, m_clrd = 0, m_gr = 0;

  always @(posedge clk or posedge reset) begin
    if (reset) begin
      for (int f = 0; f < 3; f++)
        for (int n = 0; n < NCHAN; n++) begin
          sh[f][n]  <= '0;
          act[f][n] <= '0;
        end
      m_ph <= M_IDLE; m_cnt <= 0; m_realign <= 0;
      m_err <= 0; m_cd <= 0; m_clrd <= 0; m_gr <= 0;
    end else begin
      m_cd <= 0; m_clrd <= 0; m_gr <= 0;
      if (bus.wr_valid && m_ph == M_IDLE) begin
        if (bus.wr_field == 2'd3 || int'(bus.wr_chan) >= NCHAN) m_err <= 1;
        else sh[bus.wr_field][bus.wr_chan] <= bus.wr_data;
      end
      case (m_ph)
        M_IDLE:
          if (bus.clear_req) begin
            m_ph <= M_CLEAR; m_cnt <= 0;
          end else if (bus.commit_req) begin
            m_ph <= M_PEND; m_realign <= bus.commit_realign;
          end
        M_PEND:
          if (bus.sync_tick) begin
            for (int f = 0; f < 3; f++)
              for (int n = 0; n < NCHAN; n++) act[f][n] <= sh[f][n];
            m_ph <= M_APPLY; m_cd <= 1; m_gr <= m_realign;
          end
        M_APPLY: m_ph <= M_IDLE;
        M_CLEAR: begin
          sh[0][m_cnt] <= '0;
          if (m_cnt == NCHAN - 1) begin
            m_ph <= M_IDLE; m_clrd <= 1;
          end else m_cnt <= m_cnt + 1;
        end
        default: ;
      endcase
    end
  end

  logic [W-1:0] e_amp, e_off, e_ph;
  always_comb begin
    e_amp = '0; e_off = '0; e_ph = '0;
    for (int n = 0; n < NCHAN; n++) begin
      e_amp[n*DW +: DW] = act[0][n];
      e_off[n*DW +: DW] = act[1][n];
      e_ph[n*DW +: DW]  = act[2][n];
    end
  end

  always @(negedge clk) begin
    chk("wr_ready",    W'(bus.wr_ready),    W'(m_ph == M_IDLE && !reset));
    chk("busy",        W'(bus.busy),        W'(m_ph != M_IDLE));
    chk("commit_done", W'(bus.commit_done), W'(m_cd));
    chk("clear_done",  W'(bus.clear_done),  W'(m_clrd));
    chk("gen_reset",   W'(bus.gen_reset),   W'(m_gr));
    chk("cfg_err",     W'(bus.cfg_err),     W'(m_err));
    chk("amps",        bus.amps,            e_amp);
    chk("offsets",     bus.offsets,         e_off);
    chk("phasewords",  bus.phasewords,      e_ph);
  end

  task automatic cyc();
    @(negedge clk);
    #1;
  endtask

  task automatic wr(input int chan, input int field, input logic [DW-1:0] data);
    bus.wr_valid = 1'b1;
    bus.wr_chan  = 5'(chan);
    bus.wr_field = 2'(field);
    bus.wr_data  = data;
    cyc();
    bus.wr_valid = 1'b0;
  endtask

  // Commit without realign; returns during the APPLY cycle.
  task automatic commit();
    bus.commit_req = 1'b1;
    cyc();
    bus.commit_req = 1'b0;
    bus.sync_tick  = 1'b1;
    cyc();
    bus.sync_tick  = 1'b0;
  endtask

  initial begin
    bus.wr_valid = 0; bus.wr_chan = '0; bus.wr_field = '0; bus.wr_data = '0;
    bus.commit_req = 0; bus.commit_realign = 0; bus.sync_tick = 0; bus.clear_req = 0;
    cyc(); cyc();
    reset = 1'b0;
    cyc();

    // Writes land in shadow only
    chk("s1_ready", W'(bus.wr_ready), W'(1));
    wr(5, 0, 16'h7FFF);
    chk("s1_ready2", W'(bus.wr_ready), W'(1));
    wr(31, 2, 16'h1234);
    chk("s1_amps0", bus.amps, '0);
    chk("s1_ph0", bus.phasewords, '0);

    // Commit with tick 10 cycles later
    bus.commit_req = 1'b1; bus.commit_realign = 1'b0;
    cyc();
    bus.commit_req = 1'b0;
    chk("s2_busy_pend", W'(bus.busy), W'(1));
    repeat (9) cyc();
    chk("s2_amp5_pre", W'(bus.amps[95:80]), W'(0));
    bus.sync_tick = 1'b1;
    cyc();
    bus.sync_tick = 1'b0;
    chk("s2_amp5", W'(bus.amps[95:80]), W'(16'h7FFF));
    chk("s2_ph31", W'(bus.phasewords[511:496]), W'(16'h1234));
    chk("s2_cdone", W'(bus.commit_done), W'(1));
    chk("s2_greset", W'(bus.gen_reset), W'(0));
    chk("s2_busy_apply", W'(bus.busy), W'(1));
    cyc();
    chk("s2_cdone_end", W'(bus.commit_done), W'(0));
    chk("s2_busy_end", W'(bus.busy), W'(0));

    // Tick coinciding with commit_req must not apply
    wr(6, 0, 16'h0066);
    bus.commit_req = 1'b1; bus.commit_realign = 1'b1; bus.sync_tick = 1'b1;
    cyc();
    bus.commit_req = 1'b0; bus.commit_realign = 1'b0; bus.sync_tick = 1'b0;
    chk("s3_no_apply", W'(bus.commit_done), W'(0));
    chk("s3_amp6_held", W'(bus.amps[111:96]), W'(0));
    repeat (3) cyc();
    bus.sync_tick = 1'b1;
    cyc();
    bus.sync_tick = 1'b0;
    chk("s3_cdone", W'(bus.commit_done), W'(1));
    chk("s3_greset", W'(bus.gen_reset), W'(1));
    chk("s3_amp6", W'(bus.amps[111:96]), W'(16'h0066));
    cyc();
    chk("s3_greset_end", W'(bus.gen_reset), W'(0));

    // Most negative amp and an illegal field write
    wr(0, 0, 16'h8000);
    wr(3, 3, 16'hABCD);
    chk("s4_err", W'(bus.cfg_err), W'(1));
    commit();
    chk("s4_amp0", W'(bus.amps[15:0]), W'(16'h8000));
    chk("s4_amp3", W'(bus.amps[63:48]), W'(0));
    cyc();

    // Fill all amps, commit, then clear
    for (int n = 0; n < NCHAN; n++) wr(n, 0, 16'(16'h0100 + n));
    wr(7, 1, 16'h5555);
    commit();
    cyc();
    bus.clear_req = 1'b1; bus.commit_req = 1'b1;
    cyc();
    bus.clear_req = 1'b0; bus.commit_req = 1'b0;
    for (int i = 0; i < NCHAN; i++) begin
      chk("s5_ready_low", W'(bus.wr_ready), W'(0));
      cyc();
    end
    chk("s5_cldone", W'(bus.clear_done), W'(1));
    chk("s5_ready_back", W'(bus.wr_ready), W'(1));
    chk("s5_amp31_kept", W'(bus.amps[511:496]), W'(16'h011F));
    cyc();
    chk("s5_cldone_end", W'(bus.clear_done), W'(0));
    commit();
    chk("s5_amps_zero", bus.amps, '0);
    chk("s5_off7", W'(bus.offsets[127:112]), W'(16'h5555));
    chk("s5_ph31", W'(bus.phasewords[511:496]), W'(16'h1234));
    chk("s5_err_sticky", W'(bus.cfg_err), W'(1));
    cyc();

    // Async reset during PENDING
    wr(2, 0, 16'h2222);
    commit();
    cyc();
    bus.commit_req = 1'b1;
    cyc();
    bus.commit_req = 1'b0;
    #2 reset = 1'b1;
    #1;
    chk("r1_amps", bus.amps, '0);
    chk("r1_off", bus.offsets, '0);
    chk("r1_ph", bus.phasewords, '0);
    chk("r1_busy", W'(bus.busy), W'(0));
    chk("r1_err", W'(bus.cfg_err), W'(0));
    chk("r1_cdone", W'(bus.commit_done), W'(0));
    cyc();
    reset = 1'b0;
    cyc();

    // Async reset during CLEAR at counter 17
    wr(9, 0, 16'h9999);
    commit();
    cyc();
    bus.clear_req = 1'b1;
    cyc();
    bus.clear_req = 1'b0;
    repeat (17) cyc();
    chk("r2_busy_pre", W'(bus.busy), W'(1));
    #2 reset = 1'b1;
    #1;
    chk("r2_amps", bus.amps, '0);
    chk("r2_busy", W'(bus.busy), W'(0));
    chk("r2_cldone", W'(bus.clear_done), W'(0));
    cyc();
    reset = 1'b0;
    cyc();
    chk("r2_cldone_after", W'(bus.clear_done), W'(0));

    // Random traffic
    for (int i = 0; i < 3000; i++) begin
      bus.wr_valid       = 1'($urandom_range(0, 1));
      bus.wr_chan        = 5'($urandom);
      bus.wr_field       = ($urandom_range(0, 15) == 0) ? 2'd3 : 2'($urandom_range(0, 2));
      bus.wr_data        = 16'($urandom);
      bus.commit_req     = ($urandom_range(0, 7) == 0);
      bus.commit_realign = 1'($urandom_range(0, 1));
      bus.sync_tick      = ($urandom_range(0, 5) == 0);
      bus.clear_req      = ($urandom_range(0, 60) == 0);
      cyc();
    end
    bus.wr_valid = 0; bus.commit_req = 0; bus.sync_tick = 0; bus.clear_req = 0;
    repeat (40) cyc();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
